display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL provide parameter DWELL_CYCLES, default 50_000_000, minimum cycles a grant is held (legal range 1..2^32-1).
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port i_req  input  4  per-requester display request, level-sensitive.
REQ-005 SHALL provide port i_value  input  64  requester n value at bits [16n+15:16n].
REQ-006 SHALL provide port i_blank_lz  input  1  leading-zero blanking enable.
REQ-007 SHALL provide port o_grant  output  4  one-hot current owner, all-zero when idle.
REQ-008 SHALL provide ports o_digit1..o_digit4  output  4 each  nibbles to the 4-digit display driver, digit1 = bits [3:0], digit4 = bits [15:12].
REQ-009 SHALL provide ports o_show_digit1..o_show_digit4  output  1 each  per-digit enable to the display driver.
REQ-010 SHALL provide port o_busy  output  1  high whenever o_grant is non-zero.

Function
REQ-011 SHALL implement two states: IDLE and HOLD.
REQ-012 SHALL keep a 2-bit last-owner pointer; round-robin search order starts at pointer+1 mod 4.
REQ-013 IDLE: if any i_req bit set, SHALL assert o_grant for the first requesting index in round-robin order on the next edge, load dwell counter with DWELL_CYCLES-1, enter HOLD, update pointer.
REQ-014 IDLE with i_req = 0: SHALL hold o_grant = 0, all o_show_digitN = 0, o_busy = 0.
REQ-015 HOLD: counter SHALL decrement by 1 per cycle while non-zero.
REQ-016 HOLD, owner deasserts i_req before counter reaches 0: SHALL release on next edge, same rule as counter expiry.
REQ-017 At counter = 0 or owner release: if another requester is asserted, SHALL switch o_grant directly to the next one in round-robin order (no idle cycle), reload counter, update pointer.
REQ-018 At counter = 0 with only the owner requesting: SHALL keep the grant and reload counter with DWELL_CYCLES-1.
REQ-019 At counter = 0 or release with no request: SHALL return to IDLE, o_grant = 0 on next edge.
REQ-020 Owner's value SHALL be registered into o_digitN every cycle in HOLD (1-cycle latency from i_value to o_digitN); digits SHALL freeze at last value in IDLE.
REQ-021 With i_blank_lz = 0 in HOLD: all four o_show_digitN SHALL be 1.
REQ-022 With i_blank_lz = 1 in HOLD: o_show_digit1 SHALL be 1; o_show_digitN (N=2..4) SHALL be 0 iff nibble N and all higher nibbles are zero.
REQ-023 o_grant SHALL never have more than one bit set; o_digit/o_show SHALL always correspond to the requester in o_grant on the same cycle.
REQ-024 Requests from non-owners during HOLD SHALL NOT shorten the dwell.
REQ-025 DWELL_CYCLES = 1 SHALL re-arbitrate every cycle.

Reset
REQ-026 On rst high, asynchronously: state IDLE, o_grant = 0, o_busy = 0, o_digitN = 0, o_show_digitN = 0, counter = 0, pointer = 3 (requester 0 wins first).
REQ-027 Reset asserted mid-HOLD SHALL abort the grant immediately; after deassert, arbitration restarts as from power-up.

Verification (DWELL_CYCLES = 4)
REQ-028 Reset, then i_req = 0001, i_value[15:0] = 16'h12AB -> next edge o_grant = 0001, digits 1..4 = B,A,2,1, all shows 1, o_busy = 1.
REQ-029 i_req = 0101 held constantly -> o_grant alternates 0001, 0100 every 4 cycles, no idle cycle between.
REQ-030 Owner 0 drops i_req at 2nd cycle of HOLD with i_req[2] set -> o_grant = 0100 on next edge.
REQ-031 i_blank_lz = 1, owner value 16'h0030 -> shows (d1..d4) = 1,1,0,0; value 16'h0000 -> 1,0,0,0.
REQ-032 Only owner 3 requesting for 12 cycles -> o_grant stays 1000 continuously; then i_req = 0000 -> o_grant = 0 after expiry/release, shows 0, digits retain last value.
REQ-033 rst pulsed mid-HOLD with owner 2 -> all outputs 0 during reset; after release with i_req = 1111 -> first grant 0001.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter: four-way round-robin arbiter for a shared 4-digit display.
// The current owner keeps the display for at least DWELL_CYCLES cycles. Its
// 16-bit value goes to the digit outputs with one cycle of latency. Leading
// zeros can optionally be blanked.
module display_arbiter #(
  parameter logic [31:0] DWELL_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_req,
  input  logic [63:0] i_value,
  input  logic        i_blank_lz,
  output logic [3:0]  o_grant,
  output logic [3:0]  o_digit1,
  output logic [3:0]  o_digit2,
  output logic [3:0]  o_digit3,
  output logic [3:0]  o_digit4,
  output logic        o_show_digit1,
  output logic        o_show_digit2,
  output logic        o_show_digit3,
  output logic        o_show_digit4,
  output logic        o_busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [31:0] RELOAD = DWELL_CYCLES - 32'd1;

  // Round-robin search starting one past the last owner. The last owner is
  // visited last, so it keeps the grant only when nobody else is asking.
  // Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // Digit enables. Digit 1 is always lit. A higher digit is dark only when it
  // and every digit above it are zero, and only when blanking is enabled.
  function automatic logic [3:0] show_mask(input logic [15:0] v, input logic blank);
    logic [3:0] m;
    m[0] = 1'b1;
    m[1] = !blank || (v[15:4]  != 12'd0);
    m[2] = !blank || (v[15:8]  != 8'd0);
    m[3] = !blank || (v[15:12] != 4'd0);
    return m;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  show_q, show_d;
  logic        busy_q;

  logic        arb;
  logic [2:0]  pick;
  logic [1:0]  owner_d;
  logic [15:0] owner_val;

  // Next-state: decide whether to arbitrate this edge, then format the owner's value.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    show_d    = show_q;
    owner_d   = ptr_q;
    owner_val = 16'd0;

    // Arbitration happens when idle, when the owner lets go, or when the dwell
    // has expired. Other requesters never cut the dwell short.
    arb  = (state_q == IDLE) || !i_req[ptr_q] || (cnt_q == 32'd0);
    pick = rr_pick(i_req, ptr_q);

    if (arb) begin
      if (pick[2]) begin
        state_d = HOLD;
        grant_d = 4'b0001 << pick[1:0];
        ptr_d   = pick[1:0];
        owner_d = pick[1:0];
        cnt_d   = RELOAD;
      end else begin
        state_d = IDLE;
        grant_d = 4'b0000;
        cnt_d   = 32'd0;
      end
    end else begin
      cnt_d = cnt_q - 32'd1;
    end

    // Digits follow whoever holds the grant after this edge. When the grant
    // drops, the digits freeze and the enables turn off.
    owner_val = i_value[{owner_d, 4'b0000} +: 16];
    if (grant_d != 4'b0000) begin
      digits_d = owner_val;
      show_d   = show_mask(owner_val, i_blank_lz);
    end else begin
      show_d   = 4'b0000;
    end
  end

  // State and registered outputs. Reset aborts any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 4'b0000;
      ptr_q    <= 2'd3;
      cnt_q    <= 32'd0;
      digits_q <= 16'd0;
      show_q   <= 4'b0000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      show_q   <= show_d;
      busy_q   <= |grant_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_busy        = busy_q;
  assign o_digit1      = digits_q[3:0];
  assign o_digit2      = digits_q[7:4];
  assign o_digit3      = digits_q[11:8];
  assign o_digit4      = digits_q[15:12];
  assign o_show_digit1 = show_q[0];
  assign o_show_digit2 = show_q[1];
  assign o_show_digit3 = show_q[2];
  assign o_show_digit4 = show_q[3];

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with DWELL_CYCLES = 4: a reference model plus directed scenarios.
module tb_display_arbiter;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  i_req;
  logic [63:0] i_value;
  logic        i_blank_lz;
  logic [3:0]  o_grant;
  logic [3:0]  o_digit1, o_digit2, o_digit3, o_digit4;
  logic        o_show_digit1, o_show_digit2, o_show_digit3, o_show_digit4;
  logic        o_busy;

  display_arbiter #(.DWELL_CYCLES(32'd4)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_value(i_value), .i_blank_lz(i_blank_lz),
    .o_grant(o_grant),
    .o_digit1(o_digit1), .o_digit2(o_digit2), .o_digit3(o_digit3), .o_digit4(o_digit4),
    .o_show_digit1(o_show_digit1), .o_show_digit2(o_show_digit2),
    .o_show_digit3(o_show_digit3), .o_show_digit4(o_show_digit4),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when idle), cycles held so far, last owner.
  int          m_owner;
  int          m_held;
  int          m_ptr;
  logic [15:0] m_dig;
  logic [3:0]  m_show;

  initial begin
    int nw;
    int top;
    logic [15:0] v;
    m_owner = -1; m_held = 0; m_ptr = 3; m_dig = '0; m_show = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1; m_held = 0; m_ptr = 3; m_dig = '0; m_show = '0;
      end else begin
        if (m_owner < 0 || !i_req[m_owner] || m_held >= DW) begin
          nw = -1;
          for (int k = 1; k <= 4; k++)
            if (nw < 0 && i_req[(m_ptr + k) % 4]) nw = (m_ptr + k) % 4;
          if (nw >= 0) begin
            m_owner = nw; m_ptr = nw; m_held = 1;
          end else begin
            m_owner = -1; m_held = 0;
          end
        end else begin
          m_held++;
        end
        if (m_owner >= 0) begin
          v = i_value[16*m_owner +: 16];
          m_dig = v;
          top = -1;
          for (int n = 0; n < 4; n++) if (v[4*n +: 4] != 4'd0) top = n;
          for (int n = 0; n < 4; n++) m_show[n] = (n == 0) || !i_blank_lz || (n <= top);
        end else begin
          m_show = 4'b0000;
        end
      end
    end
  end

  // Every falling edge: DUT against model.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_grant", {28'd0, o_grant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("m_busy", {31'd0, o_busy}, {31'd0, m_owner >= 0});
      chk("m_digits", {16'd0, o_digit4, o_digit3, o_digit2, o_digit1}, {16'd0, m_dig});
      chk("m_show", {28'd0, o_show_digit4, o_show_digit3, o_show_digit2, o_show_digit1},
          {28'd0, m_show});
      chk("m_onehot", $countones(o_grant) <= 1, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] digs();
    return {16'd0, o_digit4, o_digit3, o_digit2, o_digit1};
  endfunction

  function automatic logic [31:0] shows();
    return {28'd0, o_show_digit4, o_show_digit3, o_show_digit2, o_show_digit1};
  endfunction

  logic [3:0]  pat_req [4] = '{4'b0110, 4'b1001, 4'b0000, 4'b0011};
  logic [15:0] pat_val [4] = '{16'h00F0, 16'h0A00, 16'h0001, 16'hBEEF};

  initial begin
    i_req = 4'b0000; i_value = '0; i_blank_lz = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_grant", {28'd0, o_grant}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_digits", digs(), 32'd0);
    chk("rst_show", shows(), 32'd0);
    rst = 1'b0;
    tick();

    // First grant, digits B,A,2,1.
    i_value[15:0] = 16'h12AB; i_req = 4'b0001;
    tick();
    chk("first_grant", {28'd0, o_grant}, 32'h1);
    chk("first_digits", digs(), 32'h12AB);
    chk("first_show", shows(), 32'hF);
    chk("first_busy", {31'd0, o_busy}, 32'd1);

    // Two requesters alternate every 4 cycles.
    i_req = 4'b0101; i_value[47:32] = 16'h0030;
    repeat (3) tick();
    chk("alt_hold0", {28'd0, o_grant}, 32'h1);
    tick();
    chk("alt_to2", {28'd0, o_grant}, 32'h4);
    chk("alt_to2_digits", digs(), 32'h0030);
    repeat (3) tick();
    chk("alt_hold2", {28'd0, o_grant}, 32'h4);
    tick();
    chk("alt_back0", {28'd0, o_grant}, 32'h1);

    // Owner 0 lets go in its second cycle of the grant.
    tick();
    i_req = 4'b0100;
    tick();
    chk("release_to2", {28'd0, o_grant}, 32'h4);

    // Leading-zero blanking.
    i_blank_lz = 1'b1;
    tick();
    chk("blank_0030", shows(), 32'h3);
    i_value[47:32] = 16'h0000;
    tick();
    chk("blank_0000", shows(), 32'h1);
    chk("blank_0000_dig", digs(), 32'h0000);

    // Single requester 3 keeps the grant through expiries.
    i_value[63:48] = 16'h4560; i_req = 4'b1000;
    tick();
    chk("own3_grant", {28'd0, o_grant}, 32'h8);
    chk("own3_show", shows(), 32'hF);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("own3_keep", {28'd0, o_grant}, 32'h8);
    end
    i_req = 4'b0000;
    tick();
    chk("idle_grant", {28'd0, o_grant}, 32'h0);
    chk("idle_show", shows(), 32'h0);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_digits", digs(), 32'h4560);
    repeat (2) tick();
    chk("idle_frozen", digs(), 32'h4560);

    // Reset in the middle of owner 2's grant.
    i_blank_lz = 1'b0; i_value[47:32] = 16'h9876; i_req = 4'b0100;
    tick();
    chk("pre_rst_grant", {28'd0, o_grant}, 32'h4);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", {28'd0, o_grant}, 32'h0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_digits", digs(), 32'h0);
    chk("mid_rst_show", shows(), 32'h0);
    i_req = 4'b1111;
    tick();
    chk("in_rst_grant", {28'd0, o_grant}, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_grant", {28'd0, o_grant}, 32'h1);

    // Full contention rotates through all requesters.
    i_value = 64'h4444_3333_2222_1111;
    repeat (16) tick();

    // A few more request patterns, checked against the model.
    i_blank_lz = 1'b1;
    for (int p = 0; p < 4; p++) begin
      i_req = pat_req[p];
      i_value = {4{pat_val[p]}};
      repeat (6) tick();
    end

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
